// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types for the parametrised RSA modular-exponentiation core.
// FSM state encoding and counter-width helpers.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } rsa_state_e;

  localparam int RSA_WIDTH_DEF = 256;
  localparam int RSA_CNT_W     = $clog2(RSA_WIDTH_DEF + 1);

  function automatic int rsa_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rsa_core_param_if.sv
// rsa_core_param_if: request/result bundle between the RSA wrapper and core.
// master = wrapper side, slave = core side.
interface rsa_core_param_if #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = WIDTH
);
  import rsa_pkg::*;

  logic                 i_start;
  logic [WIDTH-1:0]     i_a;
  logic [EXP_WIDTH-1:0] i_d;
  logic [WIDTH-1:0]     i_n;
  logic [WIDTH-1:0]     o_a_pow_d;
  logic                 o_finished;
  logic                 o_busy;

  modport master (
    output i_start, i_a, i_d, i_n,
    input  o_a_pow_d, o_finished, o_busy
  );

  modport slave (
    input  i_start, i_a, i_d, i_n,
    output o_a_pow_d, o_finished, o_busy
  );

endinterface

// File: rtl/rsa_mont.sv
// rsa_mont: bit-serial radix-2 Montgomery product x*y*2^-WIDTH mod n.
// Start edge runs step 0; WIDTH steps, then a reduce cycle with o_finished.
module rsa_mont
  import rsa_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_s,
  output logic             o_finished
);

  localparam int CW = rsa_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [WIDTH+1:0] s_q, s_base, s_add, s_odd, s_nxt;
  logic [WIDTH-1:0] x_q, y_q, n_q, y_cur, n_cur;
  logic [CW-1:0]    cnt_q;
  logic             run_q, x_bit;

  // one Montgomery step; on start it works straight from the inputs
  always_comb begin
    s_base = i_start ? '0 : s_q;
    x_bit  = i_start ? i_x[0] : x_q[0];
    y_cur  = i_start ? i_y : y_q;
    n_cur  = i_start ? i_n : n_q;
    s_add  = s_base + (x_bit ? {2'b00, y_cur} : '0);
    s_odd  = s_add[0] ? s_add + {2'b00, n_cur} : s_add;
    s_nxt  = s_odd >> 1;
  end

  // operand registers and step counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      n_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (i_start) begin
      s_q   <= s_nxt;
      x_q   <= i_x >> 1;
      y_q   <= i_y;
      n_q   <= i_n;
      cnt_q <= CW'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        run_q <= 1'b0;
      end else begin
        s_q   <= s_nxt;
        x_q   <= x_q >> 1;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // final conditional subtract, presented in the reduce cycle
  always_comb begin
    o_finished = run_q && (cnt_q == CNT_LAST);
    o_s = WIDTH'((s_q >= {2'b00, n_q}) ? s_q - {2'b00, n_q} : s_q);
  end

endmodule

// File: rtl/rsa_core_param.sv
// rsa_core_param: a^d mod n, right-to-left binary exponentiation on Montgomery.
// Optional RSA_EARLY_EXIT_EN: stop once the remaining exponent is zero.
module rsa_core_param
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = WIDTH
) (
  input logic             i_clk,
  input logic             i_rst_n,
  rsa_core_param_if.slave bus
);

  localparam int CW = rsa_cnt_w(WIDTH);
  localparam int IW = $clog2(EXP_WIDTH + 1);
  localparam logic [CW-1:0] PREP_LAST = CW'(WIDTH);
  localparam logic [IW-1:0] IT_LAST   = IW'(EXP_WIDTH - 1);

  rsa_state_e state_q, state_d;

  logic [WIDTH-1:0]     n_q, m_q, t_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [CW-1:0]        cyc_q;
  logic [IW-1:0]        it_q;
  logic [WIDTH:0]       t_dbl;
  logic [WIDTH-1:0]     a_s, b_s;
  logic                 a_fin, b_fin;
  logic                 mont_go, iter_end;

  assign t_dbl    = {t_q, 1'b0};
  assign mont_go  = (state_q == CALC) && (cyc_q == '0);
  assign iter_end = (state_q == CALC) && a_fin && b_fin;

  rsa_mont #(.WIDTH(WIDTH)) u_mont_a (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (mont_go),
    .i_x       (m_q),
    .i_y       (t_q),
    .i_n       (n_q),
    .o_s       (a_s),
    .o_finished(a_fin)
  );

  rsa_mont #(.WIDTH(WIDTH)) u_mont_b (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (mont_go),
    .i_x       (t_q),
    .i_y       (t_q),
    .i_n       (n_q),
    .o_s       (b_s),
    .o_finished(b_fin)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.i_start) state_d = PREP;
      PREP: begin
        if (cyc_q == PREP_LAST) begin
`ifdef RSA_EARLY_EXIT_EN
          state_d = (e_q == '0) ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (iter_end) begin
          if (it_q == IT_LAST) state_d = DONE;
`ifdef RSA_EARLY_EXIT_EN
          else if ((e_q >> 1) == '0) state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture, Montgomery-form conversion and per-iteration update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_q   <= '0;
      m_q   <= '0;
      t_q   <= '0;
      e_q   <= '0;
      cyc_q <= '0;
      it_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            n_q   <= bus.i_n;
            e_q   <= bus.i_d;
            m_q   <= WIDTH'(1);
            t_q   <= bus.i_a;
            cyc_q <= '0;
            it_q  <= '0;
          end
        end
        PREP: begin
          if (cyc_q == PREP_LAST) begin
            cyc_q <= '0;
          end else begin
            if (t_dbl >= {1'b0, n_q}) t_q <= WIDTH'(t_dbl - {1'b0, n_q});
            else                      t_q <= t_dbl[WIDTH-1:0];
            cyc_q <= cyc_q + CW'(1);
          end
        end
        CALC: begin
          if (iter_end) begin
            if (e_q[0]) m_q <= a_s;
            t_q   <= b_s;
            e_q   <= e_q >> 1;
            it_q  <= it_q + IW'(1);
            cyc_q <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  // outputs decoded from state; m stays in normal form throughout
  always_comb begin
    bus.o_finished = (state_q == DONE);
    bus.o_busy     = (state_q != IDLE);
    bus.o_a_pow_d  = m_q;
  end

endmodule

// File: tb/tb_rsa_core_param.sv
// tb_rsa_core_param: randomized and directed checks of rsa_core_param, WIDTH=8.
// Reference model is plain modular exponentiation plus a latency formula.
module tb_rsa_core_param;

  localparam int W = 8;
  localparam int E = 8;

`ifdef RSA_EARLY_EXIT_EN
  localparam int LAT_7_13 = 45;
  localparam int LAT_D0   = 9;
  localparam int LAT_D1   = 18;
`else
  localparam int LAT_7_13 = 81;
  localparam int LAT_D0   = 81;
  localparam int LAT_D1   = 81;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int op_id   = 0;
  int done_id = 0;
  int m_lat   = 0;
  logic [W-1:0] m_res = '0;

  rsa_core_param_if #(.WIDTH(W), .EXP_WIDTH(E)) bus ();

  rsa_core_param #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int modexp(input int a, input int d, input int n);
    longint r = 1;
    longint b = a % n;
    for (int i = 0; i < E; i++) begin
      if (((d >> i) & 1) != 0) r = (r * b) % n;
      b = (b * b) % n;
    end
    return int'(r);
  endfunction

  function automatic int lat_of(input int d);
`ifdef RSA_EARLY_EXIT_EN
    int k = 0;
    for (int i = 0; i < E; i++)
      if (((d >> i) & 1) != 0) k = i + 1;
    return 1 + W + k * (W + 1);
`else
    return 1 + W + E * (W + 1) + 0 * d;
`endif
  endfunction

  // compare process: k = edges since the accepting edge
  initial begin : mon
    int k;
    int cur;
    k = 0;
    cur = 0;
    forever begin
      @(negedge clk);
      if (cur != op_id) begin
        cur = op_id;
        k = 0;
      end
      if (cur != done_id) begin
        chk("busy", bus.o_busy, k <= m_lat);
        chk("finished", bus.o_finished, k == m_lat);
        if (k >= m_lat) chk("result", bus.o_a_pow_d, m_res);
        if (k > m_lat) done_id = cur;
        k++;
      end
    end
  end

  // mode 1: re-pulse start mid-CALC; mode 2: pulse start in the DONE cycle
  task automatic run_op(input int a, input int d, input int n,
                        input int exp_res, input int lat, input int mode);
    @(posedge clk);
    #1;
    bus.i_a = W'(a);
    bus.i_d = E'(d);
    bus.i_n = W'(n);
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    m_lat = lat;
    m_res = W'(exp_res);
    op_id = op_id + 1;
    for (int c = 1; c <= lat + 20; c++) begin
      @(posedge clk);
      #1;
      if (done_id == op_id) break;
      if (mode == 1 && c == 40) begin
        bus.i_a = W'(a ^ 'h5A);
        bus.i_start = 1'b1;
      end
      if (mode == 1 && c == 41) begin
        bus.i_start = 1'b0;
        bus.i_a = W'(a);
      end
      if (mode == 2 && c == lat) bus.i_start = 1'b1;
      if (mode == 2 && c == lat + 1) bus.i_start = 1'b0;
    end
    bus.i_start = 1'b0;
    chk("op_done", done_id, op_id);
  endtask

  initial begin
    int n, a, d;
    bus.i_start = 1'b0;
    bus.i_a = '0;
    bus.i_d = '0;
    bus.i_n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_finished", bus.o_finished, 0);
    chk("rst_result", bus.o_a_pow_d, 0);
    #1 rst_n = 1'b1;

    chk("model_7_13", modexp(7, 13, 143), 46);
    chk("model_d0", modexp(100, 0, 143), 1);
    chk("model_a0", modexp(0, 5, 143), 0);

    run_op(7, 13, 143, 'h2E, LAT_7_13, 0);
    run_op('h55, 0, 143, 'h01, LAT_D0, 0);
    run_op('h55, 1, 143, 'h55, LAT_D1, 0);
    run_op(0, 5, 143, 'h00, lat_of(5), 0);
    run_op(7, 13, 143, 'h2E, LAT_7_13, 1);

    // abort an operation mid-CALC with reset
    @(posedge clk);
    #1;
    bus.i_a = 8'd7;
    bus.i_d = 8'd13;
    bus.i_n = 8'd143;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    chk("pre_abort_busy", bus.o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_finished", bus.o_finished, 0);
    chk("abort_result", bus.o_a_pow_d, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("abort_no_finish", bus.o_finished, 0);
      chk("abort_idle", bus.o_busy, 0);
    end
    run_op(7, 13, 143, 'h2E, LAT_7_13, 0);

    for (int i = 0; i < 24; i++) begin
      n = 2 * int'($urandom_range(1, 127)) + 1;
      a = int'($urandom_range(0, n - 1));
      d = int'($urandom_range(0, 255));
      if (i % 6 == 1) d = int'($urandom_range(0, 3));
      run_op(a, d, n, modexp(a, d, n), lat_of(d), (i % 4 == 3) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_core_param.md
Name: rsa_core_param

Overview:
- Parametrised successor to the fixed 256-bit RSA core: computes o_a_pow_d = i_a^i_d mod i_n for configurable modulus and exponent widths.
- Uses right-to-left binary exponentiation built on radix-2 Montgomery multiplication.
- Adds a busy flag, a defined fixed latency and an optional early-exit mode.
- Sits between the RSA wrapper/UART controller and the key/data registers; one operation in flight at a time.

Parameters:
- WIDTH, 256, modulus/data width in bits (WIDTH >= 8)
- EXP_WIDTH, WIDTH, exponent width in bits (1 <= EXP_WIDTH <= WIDTH)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle start request, sampled only in IDLE
- i_a  in  WIDTH  base; requires i_a < i_n
- i_d  in  EXP_WIDTH  exponent
- i_n  in  WIDTH  modulus; requires i_n odd and i_n > 1
- o_a_pow_d  out  WIDTH  result; valid from the o_finished cycle, held until next accepted start
- o_finished  out  1  one-cycle done pulse
- o_busy  out  1  high from the cycle after start acceptance through the o_finished cycle

Behaviour:
- Reset (async, i_rst_n=0) clears all state immediately:
  - o_a_pow_d=0, o_finished=0, o_busy=0, state IDLE.
  - Reset mid-operation aborts with no result; start is required again after release.
- States: IDLE -> PREP -> CALC -> DONE -> IDLE.
- IDLE:
  - On i_start=1, capture i_a, i_d, i_n into internal registers.
  - Set m=1 and t=i_a, then go to PREP.
  - Inputs are don't-care after the capture edge.
- PREP (WIDTH cycles), converts t to Montgomery form, t = a*2^WIDTH mod n:
  - Each cycle: t = 2t; if t >= n, then t = t - n.
  - Uses a WIDTH+1-bit intermediate.
- CALC: EXP_WIDTH iterations, LSB of exponent first, WIDTH+1 cycles each.
  - rsa_mont instance A computes mont(m,t); instance B computes mont(t,t), both in parallel.
  - mont(x,y) = x*y*2^-WIDTH mod n.
  - Montgomery step, WIDTH cycles, one per bit i of x: s = s + x[i]*y; if s is odd, s = s + n; then s = s >> 1.
  - s is WIDTH+2 bits wide.
  - Final subtract cycle: if s >= n, then s = s - n.
  - At iteration end: m = A only if the current exponent bit is 1, else m is unchanged; t = B always; shift the exponent right by 1.
- DONE (1 cycle): o_a_pow_d = m, o_finished = 1; next state IDLE.
- Latency:
  - o_finished rises at edge 1 + WIDTH + EXP_WIDTH*(WIDTH+1) after the edge that accepted i_start.
  - WIDTH=256: 66049 cycles. WIDTH=8: 81 cycles.
- Boundary cases:
  - i_start while busy is ignored.
  - i_start in the DONE cycle is ignored; it is accepted only in IDLE, so back-to-back starts are spaced by at least 1 IDLE cycle.
  - i_d = 0 gives result 1.
  - i_a = 0 with i_d != 0 gives result 0.
  - Behaviour is undefined if i_a >= i_n or i_n is even; no error flag.

Optional Feature:
- Macro: RSA_EARLY_EXIT_EN.
- Defined:
  - After each CALC iteration, if the shifted exponent register is all zero, go straight to DONE.
  - If the captured i_d = 0, go PREP -> DONE with no CALC.
  - Latency = 1 + WIDTH + k*(WIDTH+1), where k = index of highest set bit of i_d, plus 1 (k = 0 when i_d = 0).
- Undefined: fixed latency as above, independent of i_d. This is the default; it resists timing side channels.

Decomposition:
- Package rsa_pkg holds:
  - state enum (IDLE, PREP, CALC, DONE), 2 bits;
  - localparam for the Montgomery step-counter width, $clog2(WIDTH+1).
- One sub-module, rsa_mont (parameter WIDTH):
  - ports i_clk, i_rst_n, i_start, i_x, i_y, i_n, o_s, o_finished;
  - latency WIDTH+1 cycles;
  - instantiated twice.
- The top level holds the FSM, PREP shifter, exponent shift register and iteration counter.

Test Plan:
- WIDTH=8, n=143, a=7, d=13, start pulsed 1 cycle:
  - o_a_pow_d = 0x2E;
  - o_finished high exactly 81 cycles after acceptance, for one cycle;
  - o_busy high throughout.
- WIDTH=8, n=143: d=0 gives result 0x01; d=1, a=0x55 gives 0x55; a=0, d=5 gives 0x00. All at latency 81.
- WIDTH=256, n=0xCA3586E7...029CF831, d=0xB6ACE0B1...BCF46BD9:
  - 5 ciphertexts from enc1.bin;
  - each result's low 248 bits match the dec1.txt plaintext;
  - each finishes in 66049 cycles.
- i_start re-pulsed mid-CALC with different i_a: ignored; result still 0x2E.
- i_rst_n dropped mid-CALC:
  - all outputs 0 immediately, no o_finished;
  - after release a fresh start gives the correct result.
- With RSA_EARLY_EXIT_EN, WIDTH=8, n=143:
  - a=7, d=13 gives 0x2E at 45 cycles;
  - d=1 gives a at 18 cycles;
  - d=0 gives 0x01 at 9 cycles.
